fc_out_packer: RTL and testbench

- Downstream consumer of the LSTM fully-connected output stage.
- Takes the two-channel signed decoded output (QZ bits per channel) on each output_data_valid pulse and applies a per-channel first-order IIR smoother.
- Rescales and saturates each channel to 16 bits, buffers up to two frames, and serializes each frame as a 7-byte packet on a valid/ready byte stream toward the UART/host link.

---
 rtl/fc_out_packer_pkg.sv | 37 +++
 rtl/fc_iir_sat.sv | 64 ++++++
 rtl/fc_out_packer.sv | 156 +++++++++++++++
 tb/tb_fc_out_packer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_out_packer_pkg.sv
// Shared constants, types and packet byte mapping for the LSTM FC output packer.
package fc_out_packer_pkg;

    localparam int unsigned QZ_DEF       = 24;
    localparam int unsigned PKT_LEN      = 7;
    localparam int unsigned IDX_CHK      = PKT_LEN - 1;
    localparam logic [7:0]  HDR_BYTE_DEF = 8'hA5;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } ser_state_e;

    typedef struct packed {
        logic [7:0]  seq;
        logic [15:0] ch1;
        logic [15:0] ch0;
    } frame_t;

    // Byte idx of the packet for frame f; the last byte is the XOR of bytes 1..5.
    function automatic logic [7:0] pkt_byte(input frame_t f, input logic [2:0] idx,
                                            input logic [7:0] hdr);
        logic [7:0] b;
        case (idx)
            3'd0:    b = hdr;
            3'd1:    b = f.seq;
            3'd2:    b = f.ch0[15:8];
            3'd3:    b = f.ch0[7:0];
            3'd4:    b = f.ch1[15:8];
            3'd5:    b = f.ch1[7:0];
            3'd6:    b = f.seq ^ f.ch0[15:8] ^ f.ch0[7:0] ^ f.ch1[15:8] ^ f.ch1[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/fc_iir_sat.sv
// One channel: first-order IIR smoother (primed by the first sample after reset),
// then arithmetic right shift and clamp to signed 16 bits.
module fc_iir_sat
    import fc_out_packer_pkg::*;
#(
    parameter int unsigned QZ        = QZ_DEF,
    parameter int unsigned OUT_SHIFT = 6,
    parameter int unsigned SMOOTH_K  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          x_valid,
    input  logic [QZ-1:0] x,
    output logic          y_valid,
    output logic [15:0]   s
);

    localparam logic signed [QZ-1:0] S_MAX = QZ'(32767);
    localparam logic signed [QZ-1:0] S_MIN = QZ'(-32768);

    logic signed [QZ-1:0] y_q, y_d;
    logic                 primed_q, primed_d;
    logic                 vld_q, vld_d;
    logic signed [QZ:0]   diff;
    logic signed [QZ:0]   step;
    logic signed [QZ-1:0] sh;

    always_comb begin
        y_d      = y_q;
        primed_d = primed_q;
        vld_d    = x_valid;
        // Difference needs one extra bit; the updated state always lies between y and x.
        diff     = {x[QZ-1], x} - {y_q[QZ-1], y_q};
        step     = diff >>> SMOOTH_K;
        if (x_valid) begin
            primed_d = 1'b1;
            y_d      = primed_q ? (y_q + step[QZ-1:0]) : x;
        end

        sh = y_q >>> OUT_SHIFT;
        if (sh > S_MAX) begin
            s = 16'h7FFF;
        end else if (sh < S_MIN) begin
            s = 16'h8000;
        end else begin
            s = sh[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q      <= '0;
            primed_q <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            y_q      <= y_d;
            primed_q <= primed_d;
            vld_q    <= vld_d;
        end
    end

    assign y_valid = vld_q;

endmodule

// File: rtl/fc_out_packer.sv
// Smooths and saturates the two FC output channels, buffers two frames and
// serializes each as a 7-byte packet on a valid/ready byte stream.
module fc_out_packer #(
    parameter int unsigned QZ        = fc_out_packer_pkg::QZ_DEF,
    parameter int unsigned OUT_SHIFT = 6,
    parameter int unsigned SMOOTH_K  = 2,
    parameter logic [7:0]  HDR_BYTE  = fc_out_packer_pkg::HDR_BYTE_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2*QZ-1:0] output_data,
    input  logic            output_data_valid,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic [15:0]     drop_cnt,
    output logic            busy
);

    import fc_out_packer_pkg::*;

    logic        ch0_vld, ch1_vld;
    logic [15:0] ch0_s, ch1_s;

    fc_iir_sat #(.QZ(QZ), .OUT_SHIFT(OUT_SHIFT), .SMOOTH_K(SMOOTH_K)) u_ch0 (
        .clk     (clk),
        .rst     (rst),
        .x_valid (output_data_valid),
        .x       (output_data[QZ-1:0]),
        .y_valid (ch0_vld),
        .s       (ch0_s)
    );

    fc_iir_sat #(.QZ(QZ), .OUT_SHIFT(OUT_SHIFT), .SMOOTH_K(SMOOTH_K)) u_ch1 (
        .clk     (clk),
        .rst     (rst),
        .x_valid (output_data_valid),
        .x       (output_data[2*QZ-1:QZ]),
        .y_valid (ch1_vld),
        .s       (ch1_s)
    );

    frame_t      mem_q [2];
    frame_t      mem_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  seq_q, seq_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    ser_state_e  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    frame_t      pkt_q, pkt_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        busy_q, busy_d;

    frame_t      head, nxt;
    logic        push, accept, pop;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pkt_d      = pkt_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        head       = mem_q[rd_ptr_q];
        nxt        = mem_q[~rd_ptr_q];

        case (state_q)
            ST_IDLE: begin
                if (cnt_q != 2'd0) begin
                    pkt_d   = head;
                    idx_d   = 3'd0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = pkt_byte(pkt_q, 3'd0, HDR_BYTE);
                end else if (tx_ready) begin
                    if (idx_q == 3'(IDX_CHK)) begin
                        // The frame stays buffered until its last byte is taken.
                        pop = 1'b1;
                        if (cnt_q == 2'd2) begin
                            pkt_d     = nxt;
                            idx_d     = 3'd0;
                            tx_data_d = HDR_BYTE;
                        end else begin
                            tx_valid_d = 1'b0;
                            state_d    = ST_IDLE;
                        end
                    end else begin
                        idx_d     = idx_q + 3'd1;
                        tx_data_d = pkt_byte(pkt_q, idx_q + 3'd1, HDR_BYTE);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        push   = ch0_vld & ch1_vld;
        accept = push && ((cnt_q != 2'd2) || pop);
        mem_d  = mem_q;
        if (accept) begin
            mem_d[wr_ptr_q] = '{seq: seq_q, ch1: ch1_s, ch0: ch0_s};
        end
        wr_ptr_d   = wr_ptr_q ^ accept;
        rd_ptr_d   = rd_ptr_q ^ pop;
        cnt_d      = cnt_q + {1'b0, accept} - {1'b0, pop};
        seq_d      = seq_q + {7'd0, accept};
        drop_cnt_d = drop_cnt_q;
        if (push && !accept && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        busy_d = (cnt_d != 2'd0) || (state_d == ST_SEND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q      <= '{default: '0};
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= '0;
            seq_q      <= '0;
            drop_cnt_q <= '0;
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            pkt_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            seq_q      <= seq_d;
            drop_cnt_q <= drop_cnt_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            pkt_q      <= pkt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign drop_cnt = drop_cnt_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_fc_out_packer.sv
// Directed bench for fc_out_packer with a byte scoreboard fed by a filter/scale model.
module tb_fc_out_packer;

    localparam int K_TB  = 2;
    localparam int SH_TB = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] output_data = '0;
    logic        output_data_valid = 1'b0;
    logic        tx_ready = 1'b1;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [15:0] drop_cnt;
    logic        busy;

    always #5 clk = ~clk;

    fc_out_packer #(.QZ(24), .OUT_SHIFT(6), .SMOOTH_K(2), .HDR_BYTE(8'hA5)) dut (
        .clk               (clk),
        .rst               (rst),
        .output_data       (output_data),
        .output_data_valid (output_data_valid),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .drop_cnt          (drop_cnt),
        .busy              (busy)
    );

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    int         y_m[2];
    bit         primed_m = 1'b0;
    logic [7:0] seq_m = 8'd0;
    int         mon_idx = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input int v);
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    function automatic int rnd24();
        logic [23:0] r;
        r = 24'($urandom);
        return {{8{r[23]}}, r};
    endfunction

    task automatic model_step(input int x0, input int x1,
                              output logic [15:0] s0, output logic [15:0] s1);
        int xs[2];
        logic [15:0] ss[2];
        xs[0] = x0;
        xs[1] = x1;
        for (int c = 0; c < 2; c++) begin
            if (!primed_m) y_m[c] = xs[c];
            else           y_m[c] = y_m[c] + ((xs[c] - y_m[c]) >>> K_TB);
            ss[c] = sat16(y_m[c] >>> SH_TB);
        end
        primed_m = 1'b1;
        s0 = ss[0];
        s1 = ss[1];
    endtask

    task automatic push_lit(input logic [7:0] b0, b1, b2, b3, b4, b5, b6);
        exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2);
        exp_q.push_back(b3); exp_q.push_back(b4); exp_q.push_back(b5);
        exp_q.push_back(b6);
    endtask

    task automatic push_pkt(input logic [7:0] sq, input logic [15:0] a, input logic [15:0] b);
        push_lit(8'hA5, sq, a[15:8], a[7:0], b[15:8], b[7:0],
                 sq ^ a[15:8] ^ a[7:0] ^ b[15:8] ^ b[7:0]);
    endtask

    // mode: 0 = frame expected to be dropped, 1 = model packet queued,
    // 2 = accepted but the caller queued literal bytes
    task automatic send_frame(input int c0, input int c1, input int mode);
        logic [15:0] s0, s1;
        model_step(c0, c1, s0, s1);
        if (mode == 1) push_pkt(seq_m, s0, s1);
        if (mode != 0) seq_m = seq_m + 8'd1;
        @(posedge clk); #1;
        output_data = {c1[23:0], c0[23:0]};
        output_data_valid = 1'b1;
        @(posedge clk); #1;
        output_data_valid = 1'b0;
    endtask

    task automatic drain(input int budget, input bit rnd);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (rnd) tx_ready = 1'($urandom_range(0, 1));
            if (exp_q.size() == 0 && busy == 1'b0) break;
        end
        tx_ready = 1'b1;
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        chk("drain_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        output_data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        primed_m = 1'b0;
        seq_m = 8'd0;
        @(negedge clk);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mon_idx = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {31'd0, tx_valid}, 32'd1);
                chk("stall_data", {24'd0, tx_data}, {24'd0, prev_data});
            end
            if (mon_idx != 0) chk("pkt_cont", {31'd0, tx_valid}, 32'd1);
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_byte", 32'(exp_q.size()), 32'd1);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk($sformatf("byte%0d", mon_idx), {24'd0, tx_data}, {24'd0, e});
                end
                mon_idx = (mon_idx == 6) ? 0 : mon_idx + 1;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data = tx_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Basic packet and latency
        push_lit(8'hA5, 8'h00, 8'h00, 8'h19, 8'hFF, 8'hCE, 8'h28);
        send_frame(1600, -3145, 2);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("lat_pre_valid", {31'd0, tx_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_hdr_valid", {31'd0, tx_valid}, 32'd1);
        chk("lat_hdr_data", {24'd0, tx_data}, 32'h0000_00A5);
        drain(50, 1'b0);
        chk("basic_drop", {16'd0, drop_cnt}, 32'd0);

        // Saturation
        do_reset();
        push_lit(8'hA5, 8'h00, 8'h7F, 8'hFF, 8'h80, 8'h00, 8'h00);
        send_frame(8388607, -8388608, 2);
        drain(50, 1'b0);

        // Filter response to a step down
        do_reset();
        push_lit(8'hA5, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h04);
        send_frame(65536, 0, 2);
        drain(50, 1'b0);
        push_lit(8'hA5, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h02);
        send_frame(0, 0, 2);
        drain(50, 1'b0);
        push_lit(8'hA5, 8'h02, 8'h02, 8'h40, 8'h00, 8'h00, 8'h40);
        send_frame(0, 0, 2);
        drain(50, 1'b0);

        // Backpressure with pairs of frames (exercises back-to-back packets)
        do_reset();
        for (int p = 0; p < 4; p++) begin
            send_frame(rnd24(), rnd24(), 1);
            send_frame(rnd24(), rnd24(), 1);
            drain(400, 1'b1);
        end
        chk("bp_drop", {16'd0, drop_cnt}, 32'd0);

        // Overflow: two buffered, two dropped
        do_reset();
        tx_ready = 1'b0;
        send_frame(6400, -6400, 1);
        send_frame(12800, 3200, 1);
        send_frame(-64000, 64000, 0);
        send_frame(640000, -640000, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ovf_drop", {16'd0, drop_cnt}, 32'd2);
        chk("ovf_stalled_valid", {31'd0, tx_valid}, 32'd1);
        chk("ovf_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        drain(100, 1'b0);
        send_frame(5000, -5000, 1);
        drain(50, 1'b0);
        chk("ovf_drop_after", {16'd0, drop_cnt}, 32'd2);

        // Reset in the middle of a packet
        do_reset();
        send_frame(320000, -320000, 1);
        drain(50, 1'b0);
        send_frame(-320000, 320000, 1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (mon_idx == 4) break;
        end
        chk("rst_wait_idx", 32'(mon_idx), 32'd4);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("midrst_drop", {16'd0, drop_cnt}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        primed_m = 1'b0;
        seq_m = 8'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        send_frame(123456, -654321, 1);
        drain(50, 1'b0);
        chk("midrst_drop_after", {16'd0, drop_cnt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
